// File: rtl/spi_reg_access_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_access_pkg
// Shared definitions for the SPI register-access front end:
//   - FSM state encodings (plain localparams so older tools can consume them)
//   - frame length and field offset helpers, reused by whoever instantiates
//     the SPI master next to this block to size its length port.
// -----------------------------------------------------------------------------
package spi_reg_access_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ISSUE    = 3'd1;
    localparam state_t ST_WAIT_RSP = 3'd2;
    localparam state_t ST_RESPOND  = 3'd3;
    localparam state_t ST_DRAIN    = 3'd4;

    // Number of bits that carry information in one frame: {rw, addr, data}.
    function automatic int frame_len(input int addr_width, input int data_width);
        return 1 + addr_width + data_width;
    endfunction

    // The frame is left-justified in the master word, so the rw bit is the
    // word MSB and the fields follow downwards; the low bits are padding.
    function automatic int rw_pos(input int max_len);
        return max_len - 1;
    endfunction

    function automatic int addr_lsb(input int addr_width, input int max_len);
        return max_len - 1 - addr_width;
    endfunction

    function automatic int data_lsb(input int addr_width, input int data_width,
                                    input int max_len);
        return max_len - 1 - addr_width - data_width;
    endfunction

endpackage

// File: rtl/spi_reg_access.sv
// -----------------------------------------------------------------------------
// spi_reg_access
// Packs single register read/write requests into one SPI frame {rw, addr,
// data} for the quick_spi master, collects the master's read word and returns
// one response per request. A response timeout guarantees forward progress;
// after a timeout the late master word is drained and discarded.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_*                    request channel (valid/ready, read, addr, wdata)
//   rsp_*                    response channel (valid/ready, rdata, read, err)
//   busy_o                   high whenever the FSM is not idle
//   spi_wrdata_*             frame word handshake towards the master
//   spi_rddata_*             received word handshake from the master
//
// state     | meaning
// ----------+----------------------------------------------------------------
// IDLE      | ready for a request
// ISSUE     | frame offered to the master, waiting for wrdata handshake
// WAIT_RSP  | waiting for the master's received word, timeout running
// RESPOND   | response held until the requester consumes it
// DRAIN     | timed out earlier; swallow the master's late word
// -----------------------------------------------------------------------------
module spi_reg_access
    import spi_reg_access_pkg::*;
#(
    parameter int ADDR_WIDTH      = 6,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_DATA_LENGTH = 16,
    parameter bit READ_BIT_VALUE  = 1'b1,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,

    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic                               req_read_i,
    input  logic [ADDR_WIDTH-1:0]              req_addr_i,
    input  logic [DATA_WIDTH-1:0]              req_wdata_i,

    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic [DATA_WIDTH-1:0]              rsp_rdata_o,
    output logic                               rsp_read_o,
    output logic                               rsp_err_o,

    output logic                               busy_o,

    output logic                               spi_wrdata_valid_o,
    input  logic                               spi_wrdata_ready_i,
    output logic [$clog2(MAX_DATA_LENGTH)-1:0] spi_wrdata_len_o,
    output logic [MAX_DATA_LENGTH-1:0]         spi_wrdata_o,
    input  logic                               spi_rddata_valid_i,
    output logic                               spi_rddata_ready_o,
    input  logic [MAX_DATA_LENGTH-1:0]         spi_rddata_i
);

    localparam int LEN_W     = $clog2(MAX_DATA_LENGTH);
    localparam int FRAME_LEN = frame_len(ADDR_WIDTH, DATA_WIDTH);
    localparam int RW_POS    = rw_pos(MAX_DATA_LENGTH);
    localparam int ADDR_LSB  = addr_lsb(ADDR_WIDTH, MAX_DATA_LENGTH);
    localparam int DATA_LSB  = data_lsb(ADDR_WIDTH, DATA_WIDTH, MAX_DATA_LENGTH);

    localparam logic [LEN_W-1:0] FRAME_LEN_W = LEN_W'(FRAME_LEN);

    // A zero timeout disables the check; keep the counter at least one bit
    // wide so the datapath stays well-formed in that case.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // The frame must fit strictly inside the master word.
    if (!(FRAME_LEN < MAX_DATA_LENGTH)) begin : g_frame_too_long
        $error("spi_reg_access: 1+ADDR_WIDTH+DATA_WIDTH must be < MAX_DATA_LENGTH");
    end

    state_t                    state_q,  state_d;
    logic                      read_q,   read_d;
    logic [MAX_DATA_LENGTH-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]          cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0]     rdata_q,  rdata_d;
    logic                      err_q,    err_d;
    logic                      drain_q,  drain_d;

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        drain_d = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    read_d  = req_read_i;
                    frame_d = '0;
                    frame_d[RW_POS] = req_read_i ? READ_BIT_VALUE : ~READ_BIT_VALUE;
                    frame_d[ADDR_LSB +: ADDR_WIDTH] = req_addr_i;
                    frame_d[DATA_LSB +: DATA_WIDTH] = req_read_i ? '0 : req_wdata_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (spi_wrdata_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // Real data beats a coincident timeout.
                if (spi_rddata_valid_i) begin
                    rdata_d = read_q ? spi_rddata_i[DATA_WIDTH-1:0] : '0;
                    err_d   = 1'b0;
                    state_d = ST_RESPOND;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    state_d = ST_RESPOND;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready_i) begin
                    state_d = drain_q ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (spi_rddata_valid_i) begin
                    drain_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            read_q  <= 1'b0;
            frame_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            drain_q <= drain_d;
        end
    end

    assign req_ready_o        = (state_q == ST_IDLE);
    assign busy_o             = (state_q != ST_IDLE);
    assign spi_wrdata_valid_o = (state_q == ST_ISSUE);
    assign spi_wrdata_len_o   = FRAME_LEN_W;
    assign spi_wrdata_o       = frame_q;
    assign spi_rddata_ready_o = (state_q == ST_WAIT_RSP) || (state_q == ST_DRAIN);
    assign rsp_valid_o        = (state_q == ST_RESPOND);
    assign rsp_rdata_o        = rdata_q;
    assign rsp_read_o         = read_q;
    assign rsp_err_o          = err_q;

    // Only the low DATA_WIDTH bits of the received word carry read data.
    logic unused_rddata_hi;
    assign unused_rddata_hi = ^spi_rddata_i[MAX_DATA_LENGTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_spi_reg_access.sv
module tb_spi_reg_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_read;
    logic [5:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_ready, rsp_read, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        wr_valid, wr_ready;
    logic [3:0]  wr_len;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_reg_access #(
        .ADDR_WIDTH(6), .DATA_WIDTH(8), .MAX_DATA_LENGTH(16),
        .READ_BIT_VALUE(1'b1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_read_i(req_read),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_read_o(rsp_read), .rsp_err_o(rsp_err),
        .busy_o(busy),
        .spi_wrdata_valid_o(wr_valid), .spi_wrdata_ready_i(wr_ready),
        .spi_wrdata_len_o(wr_len), .spi_wrdata_o(wr_data),
        .spi_rddata_valid_i(rd_valid), .spi_rddata_ready_o(rd_ready),
        .spi_rddata_i(rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at the negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request for one cycle (accepted from IDLE), leaving ISSUE active.
    task automatic send(input logic rd, input logic [5:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_read = rd; req_addr = a; req_wdata = d;
        chk("req_ready_idle", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; wr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_rd_ready", rd_ready, 1'b0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_read", rsp_read, 1'b0);
        rst_n = 1'b1;
        step();
        chk("idle_req_ready", req_ready, 1'b1);

        // Write 0x2A <= 0xC3, master ready immediately.
        wr_ready = 1'b1;
        send(1'b0, 6'h2A, 8'hC3);
        chk("wr_valid_n1", wr_valid, 1'b1);
        chk("wr_frame", wr_data, 16'h5586);
        chk("wr_len", wr_len, 4'd15);
        chk("wr_busy", busy, 1'b1);
        step();
        wr_ready = 1'b0;
        chk("wr_valid_one_cycle", wr_valid, 1'b0);
        chk("wr_rd_ready", rd_ready, 1'b1);
        rd_valid = 1'b1; rd_data = 16'hFFFF;
        step();
        rd_valid = 1'b0;
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_rdata", rsp_rdata, 8'h00);
        chk("wr_rsp_read", rsp_read, 1'b0);
        chk("wr_rsp_err", rsp_err, 1'b0);
        chk("wr_rsp_rd_ready", rd_ready, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("wr_back_idle", req_ready, 1'b1);
        chk("wr_rsp_gone", rsp_valid, 1'b0);

        // Read 0x05 with wrdata backpressure and response backpressure.
        send(1'b1, 6'h05, 8'hEE);
        for (int i = 0; i < 5; i++) begin
            chk("rd_bp_valid", wr_valid, 1'b1);
            chk("rd_bp_frame", wr_data, 16'h8A00);
            step();
        end
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        chk("rd_wait_rd_ready", rd_ready, 1'b1);
        rd_valid = 1'b1; rd_data = 16'h12A5;
        step();
        rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rd_rsp_valid_hold", rsp_valid, 1'b1);
            chk("rd_rsp_rdata", rsp_rdata, 8'hA5);
            chk("rd_rsp_read", rsp_read, 1'b1);
            chk("rd_rsp_err", rsp_err, 1'b0);
            chk("rd_no_req_ready", req_ready, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rd_back_idle", req_ready, 1'b1);

        // Timeout: no master data for 8 cycles after WAIT_RSP entry.
        wr_ready = 1'b1;
        send(1'b1, 6'h11, 8'h00);
        step();
        wr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to_no_rsp_yet", rsp_valid, 1'b0);
            step();
        end
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 8'h00);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_busy", busy, 1'b1);
            chk("drain_no_req_ready", req_ready, 1'b0);
            chk("drain_rd_ready", rd_ready, 1'b1);
            chk("drain_no_rsp", rsp_valid, 1'b0);
            step();
        end
        rd_valid = 1'b1; rd_data = 16'h00BB;
        step();
        rd_valid = 1'b0;
        chk("drain_done_idle", req_ready, 1'b1);
        chk("drain_no_second_rsp", rsp_valid, 1'b0);
        step();
        chk("drain_still_no_rsp", rsp_valid, 1'b0);

        // Data arriving on the timeout cycle wins.
        wr_ready = 1'b1;
        send(1'b1, 6'h3F, 8'h00);
        chk("sim_frame", wr_data, 16'hFE00);
        step();
        wr_ready = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rd_valid = 1'b1; rd_data = 16'h3477;
        step();
        rd_valid = 1'b0;
        chk("sim_rsp_valid", rsp_valid, 1'b1);
        chk("sim_rsp_err", rsp_err, 1'b0);
        chk("sim_rsp_rdata", rsp_rdata, 8'h77);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("sim_back_idle", req_ready, 1'b1);

        // Write with all-ones fields, then reset while waiting for data.
        wr_ready = 1'b1;
        send(1'b0, 6'h3F, 8'hFF);
        chk("ones_frame", wr_data, 16'h7FFE);
        step();
        wr_ready = 1'b0;
        chk("pre_rst_rd_ready", rd_ready, 1'b1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rd_ready", rd_ready, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_wr_valid", wr_valid, 1'b0);
        chk("mid_rst_err", rsp_err, 1'b0);
        rst_n = 1'b1;
        step();
        chk("post_rst_req_ready", req_ready, 1'b1);
        chk("post_rst_no_rsp", rsp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_access.md
Name: spi_reg_access

Overview:
Register-access front end that sits directly upstream of the team's SPI master (quick_spi). It accepts single register read/write requests and packs each into one SPI frame of {rw, addr, data}. It drives the master's wrdata handshake, consumes the master's rddata handshake, extracts read data and returns one response per request. A response timeout guarantees forward progress even if the master stalls.

Parameters:
ADDR_WIDTH, 6, register address bits.
DATA_WIDTH, 8, register data bits.
MAX_DATA_LENGTH, 16, must equal the master's MAX_DATA_LENGTH. Elaboration fails unless 1+ADDR_WIDTH+DATA_WIDTH < MAX_DATA_LENGTH.
READ_BIT_VALUE, 1, value of the rw bit that marks a read.
TIMEOUT_CYCLES, 4096, clocks to wait for master read data. 0 disables the timeout.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high with req_valid_i
req_read_i  in  1  1 = read, 0 = write
req_addr_i  in  ADDR_WIDTH  register address
req_wdata_i  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when high with rsp_valid_o
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and on error)
rsp_read_o  out  1  echo of req_read_i
rsp_err_o  out  1  timeout occurred
busy_o  out  1  high when not in IDLE
spi_wrdata_valid_o  out  1  to master wrdata_valid_i
spi_wrdata_ready_i  in  1  from master wrdata_ready_o
spi_wrdata_len_o  out  $clog2(MAX_DATA_LENGTH)  constant FRAME_LEN
spi_wrdata_o  out  MAX_DATA_LENGTH  frame word
spi_rddata_valid_i  in  1  from master rddata_valid_o
spi_rddata_ready_o  out  1  to master rddata_ready_i
spi_rddata_i  in  MAX_DATA_LENGTH  from master rddata_o

Behaviour:
- FRAME_LEN = 1+ADDR_WIDTH+DATA_WIDTH. The frame is {rw, addr, data}, left-justified in spi_wrdata_o; low unused bits are 0. The MSB is transmitted first. For a read, the data field is 0.
- Read data = spi_rddata_i[DATA_WIDTH-1:0], i.e. the last DATA_WIDTH bits clocked in. spi_rddata_mask is not used.
- States: IDLE, ISSUE, WAIT_RSP, RESPOND, DRAIN.
- IDLE: req_ready_o=1. On accept, register read/addr/wdata and build the frame; next state ISSUE.
- ISSUE: spi_wrdata_valid_o=1, with frame and len held stable. On spi_wrdata_ready_i, go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP: spi_rddata_ready_o=1.
  - On spi_rddata_valid_i, capture data (or 0 for a write) with err=0; next state RESPOND.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no valid, set err=1, rdata=0 and drain_pending=1; next state RESPOND.
  - If valid and the timeout hit occur in the same cycle, valid wins and err=0.
- RESPOND: rsp_valid_o=1, outputs stable, spi_rddata_ready_o=0. On rsp_ready_i, go to DRAIN if drain_pending, else IDLE.
- DRAIN: spi_rddata_ready_o=1 and the late master response is discarded. On spi_rddata_valid_i, clear drain_pending and go to IDLE. There is no timeout in DRAIN.
- Latency (request accepted at cycle N, master ready immediately): spi_wrdata_valid_o high at N+1. Response valid 1 cycle after the rddata handshake cycle.
- A new request is never accepted while a master transaction is outstanding (req_ready_o is high only in IDLE).
- Reset (rst_ni=0 at a posedge): state IDLE, all valids 0, spi_rddata_ready_o 0, rsp_rdata_o 0, rsp_err_o 0, rsp_read_o 0, drain_pending 0, counter 0, busy_o 0.
  - Reset mid-transaction abandons it with no response. The master is reset by the same source.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Decomposition:
- Shared package: state encoding localparams, FRAME_LEN and frame field offset functions. The master instance reuses these for the len width.
- No sub-module beyond reusing the existing timer (start = ISSUE handshake, count = TIMEOUT_CYCLES) for the timeout if its width suffices. Otherwise use an inline counter.

Test Plan:
- Write: addr 0x2A, wdata 0xC3, master ready immediately -> spi_wrdata_o=0x5586, len=15, valid for exactly 1 cycle. Master returns rddata 0xFFFF -> rsp rdata=0x00, read=0, err=0.
- Read: addr 0x05 -> spi_wrdata_o=0x8A00. Master returns spi_rddata_i=0x12A5 -> rsp_rdata_o=0xA5, rsp_read_o=1, err=0.
- Backpressure: spi_wrdata_ready_i low 5 cycles -> valid and frame held constant. rsp_ready_i low 3 cycles -> rsp outputs stable, and no new req_ready_o until consumed.
- Timeout with TIMEOUT_CYCLES=8: no rddata -> rsp err=1, rdata=0 exactly 8 cycles after WAIT_RSP entry. A later rddata_valid is drained, then req_ready_o returns; no second response.
- Simultaneous: rddata_valid on the timeout cycle -> err=0 with real data. Reset asserted in WAIT_RSP -> all outputs reset next cycle, req_ready_o=1 the cycle after.
